// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel
// command staging applied only at period boundaries, dead time on reversal.

module pwm_ch #(
    parameter int DEAD_PERIODS = 2,
    parameter int CNT_W        = 10,
    parameter int DEAD_W       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic [CNT_W-1:0] period_cnt,
    input  logic             accept,
    input  logic [15:0]      cmd_data,
    output logic             pending,
    output logic             spd,
    output logic             dir
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    logic [0:0]        state;
    logic [15:0]       pend_data;
    logic [14:0]       duty_act;
    logic              dir_act;
    logic [DEAD_W-1:0] dead_cnt;
    logic              reversal;

    // A reversal only needs a dead gap if the output is actually being driven.
    assign reversal = (pend_data[15] != dir_act) && (duty_act != '0) && (DEAD_PERIODS > 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            pending   <= 1'b0;
            pend_data <= '0;
            duty_act  <= '0;
            dir_act   <= 1'b0;
            dead_cnt  <= '0;
            spd       <= 1'b0;
            dir       <= 1'b0;
        end else begin
            if (boundary) begin
                case (state)
                    ST_RUN: begin
                        if (pending) begin
                            if (reversal) begin
                                duty_act <= '0;
                                dead_cnt <= DEAD_W'(DEAD_PERIODS - 1);
                                state    <= ST_DEAD;
                            end else begin
                                duty_act <= pend_data[14:0];
                                dir_act  <= pend_data[15];
                                pending  <= 1'b0;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (dead_cnt == '0) begin
                            duty_act <= pend_data[14:0];
                            dir_act  <= pend_data[15];
                            pending  <= 1'b0;
                            state    <= ST_RUN;
                        end else begin
                            dead_cnt <= dead_cnt - DEAD_W'(1);
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
            // Accept is only possible with pending clear, so it never races the boundary update.
            if (accept) begin
                pending   <= 1'b1;
                pend_data <= cmd_data;
            end
            spd <= (15'(period_cnt) < duty_act);
            dir <= dir_act;
        end
    end
endmodule

module pwm_multi_ch #(
    parameter int NUM_CH       = 2,
    parameter int PRESCALE     = 25,
    parameter int PERIOD       = 1000,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
    input  logic [15:0]                               cmd_data,
    output logic [NUM_CH-1:0]                         spd,
    output logic [NUM_CH-1:0]                         dir,
    output logic                                      frame_tick
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    logic [PRE_W-1:0]  pre_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              tick;
    logic              boundary;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] accept;

    assign tick     = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (period_cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt    <= '0;
            period_cnt <= '0;
            frame_tick <= 1'b0;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + PRE_W'(1);
            frame_tick <= boundary;
            if (tick)
                period_cnt <= (period_cnt == CNT_W'(PERIOD - 1)) ? '0 : period_cnt + CNT_W'(1);
        end
    end

    // Out-of-range channel indices match no lane and so read as not ready.
    always_comb begin
        cmd_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (cmd_ch == CH_W'(i))
                cmd_ready = !pending[i];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign accept[g] = cmd_valid && cmd_ready && (cmd_ch == CH_W'(g));

        pwm_ch #(
            .DEAD_PERIODS (DEAD_PERIODS),
            .CNT_W        (CNT_W),
            .DEAD_W       (DEAD_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .boundary   (boundary),
            .period_cnt (period_cnt),
            .accept     (accept[g]),
            .cmd_data   (cmd_data),
            .pending    (pending[g]),
            .spd        (spd[g]),
            .dir        (dir[g])
        );
    end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch with PRESCALE=2, PERIOD=10 (20 clks/period).
// cyc counts posedges since reset release; all sampling is on negedges.

module tb_pwm_multi_ch;
    localparam int NUM_CH = 2, PRESCALE = 2, PERIOD = 10, DEAD_PERIODS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [0:0]  cmd_ch = 1'b0;
    logic [15:0] cmd_data = '0;
    logic [1:0]  spd, dir;
    logic        frame_tick;
    int          checks = 0, errors = 0;
    int          cyc = 0;

    pwm_multi_ch #(
        .NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .PERIOD(PERIOD), .DEAD_PERIODS(DEAD_PERIODS)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_data(cmd_data), .spd(spd), .dir(dir), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    // spd value seen after posedge e for a duty d held over the preceding cycle
    function automatic logic exp_pwm(input int e, input int d);
        return ((((e - 1) / 2) % 10) < d);
    endfunction

    task automatic wait_cyc(input int k);
        int n = 0;
        while (cyc < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != k) begin
            checks++; errors++;
            $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, k);
        end
    endtask

    task automatic test_reset();
        logic exp_ft;
        rst = 1'b1; cmd_valid = 1'b0; cmd_ch = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (spd !== 2'b00) begin errors++; $display("FAIL rst_spd: got %b want 00", spd); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL rst_dir: got %b want 00", dir); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_ft: got %b want 0", frame_tick); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_rdy0: got %b want 1", cmd_ready); end
        cmd_ch = 1'b1; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_rdy1: got %b want 1", cmd_ready); end
        cmd_ch = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 60; e++) begin
            wait_cyc(e);
            exp_ft = (e > 0) && (e % 20 == 0);
            checks++; if (frame_tick !== exp_ft) begin errors++; $display("FAIL idle_ft@%0d: got %b want %b", e, frame_tick, exp_ft); end
            checks++; if (spd !== 2'b00 || dir !== 2'b00) begin errors++; $display("FAIL idle_out@%0d: spd=%b dir=%b want 00/00", e, spd, dir); end
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_rdy@%0d: got %b want 1", e, cmd_ready); end
        end
    endtask

    task automatic test_duty();
        int highs = 0;
        wait_cyc(62);
        cmd_ch = 1'b0; cmd_data = 16'h0003; cmd_valid = 1'b1;
        wait_cyc(63);
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL duty_rdy_fall: got %b want 0", cmd_ready); end
        wait_cyc(79);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL duty_rdy_hold: got %b want 0", cmd_ready); end
        wait_cyc(80);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL duty_rdy_rise: got %b want 1", cmd_ready); end
        checks++; if (spd[0] !== 1'b0) begin errors++; $display("FAIL duty_pre: got %b want 0", spd[0]); end
        for (int e = 81; e <= 100; e++) begin
            wait_cyc(e);
            if (spd[0] === 1'b1) highs++;
            checks++; if (spd[0] !== exp_pwm(e, 3)) begin errors++; $display("FAIL duty_spd0@%0d: got %b want %b", e, spd[0], exp_pwm(e, 3)); end
            checks++; if (spd[1] !== 1'b0) begin errors++; $display("FAIL duty_spd1@%0d: got %b want 0", e, spd[1]); end
        end
        checks++; if (highs != 6) begin errors++; $display("FAIL duty_highs: got %0d want 6", highs); end
    endtask

    task automatic test_saturate();
        wait_cyc(100);
        cmd_ch = 1'b1; cmd_data = 16'h7FFF; cmd_valid = 1'b1;
        for (int e = 101; e <= 180; e++) begin
            wait_cyc(e);
            if (e >= 121) begin
                checks++; if (spd[1] !== (e <= 160)) begin errors++; $display("FAIL sat_spd1@%0d: got %b want %b", e, spd[1], (e <= 160)); end
            end
            checks++; if (spd[0] !== exp_pwm(e, 3)) begin errors++; $display("FAIL sat_spd0@%0d: got %b want %b", e, spd[0], exp_pwm(e, 3)); end
            if (e == 101) begin cmd_valid = 1'b0; cmd_ch = 1'b0; end
            if (e == 140) begin
                cmd_ch = 1'b1; #1;
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL sat_rdy1: got %b want 1", cmd_ready); end
                cmd_data = 16'h0000; cmd_valid = 1'b1;
            end
            if (e == 141) begin cmd_valid = 1'b0; cmd_ch = 1'b0; end
        end
    endtask

    task automatic test_reversal();
        logic exp_s;
        wait_cyc(180);
        cmd_ch = 1'b0; cmd_data = 16'h8005; cmd_valid = 1'b1;
        for (int e = 181; e <= 260; e++) begin
            wait_cyc(e);
            exp_s = (e <= 200) ? exp_pwm(e, 3) : (e <= 240) ? 1'b0 : exp_pwm(e, 5);
            checks++; if (spd[0] !== exp_s) begin errors++; $display("FAIL rev_spd0@%0d: got %b want %b", e, spd[0], exp_s); end
            checks++; if (dir[0] !== (e > 240)) begin errors++; $display("FAIL rev_dir0@%0d: got %b want %b", e, dir[0], (e > 240)); end
            checks++; if (spd[1] !== 1'b0) begin errors++; $display("FAIL rev_spd1@%0d: got %b want 0", e, spd[1]); end
            checks++; if (cmd_ready !== (e >= 240)) begin errors++; $display("FAIL rev_rdy@%0d: got %b want %b", e, cmd_ready, (e >= 240)); end
            if (e == 181) cmd_valid = 1'b0;
            // attempted override during dead time must be ignored
            if (e == 210) begin cmd_data = 16'h0001; cmd_valid = 1'b1; end
            if (e == 211) cmd_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        wait_cyc(262);
        cmd_ch = 1'b0; cmd_data = 16'h8002; cmd_valid = 1'b1;
        wait_cyc(263);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy0: got %b want 0", cmd_ready); end
        cmd_data = 16'h8007;
        wait_cyc(264);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy0_hold: got %b want 0", cmd_ready); end
        cmd_ch = 1'b1; cmd_data = 16'h0004; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1: got %b want 1", cmd_ready); end
        wait_cyc(265);
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy1_fall: got %b want 0", cmd_ready); end
        wait_cyc(280);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1_rise: got %b want 1", cmd_ready); end
        for (int e = 281; e <= 340; e++) begin
            wait_cyc(e);
            checks++; if (spd[0] !== exp_pwm(e, 2)) begin errors++; $display("FAIL bp_spd0@%0d: got %b want %b", e, spd[0], exp_pwm(e, 2)); end
            checks++; if (spd[1] !== exp_pwm(e, (e <= 320) ? 4 : 6)) begin errors++; $display("FAIL bp_spd1@%0d: got %b want %b", e, spd[1], exp_pwm(e, (e <= 320) ? 4 : 6)); end
            checks++; if (dir !== 2'b01) begin errors++; $display("FAIL bp_dir@%0d: got %b want 01", e, dir); end
            if (e == 299) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bnd_rdy_pre: got %b want 1", cmd_ready); end
                cmd_data = 16'h0006; cmd_valid = 1'b1;
            end
            if (e == 300) begin
                cmd_valid = 1'b0;
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bnd_rdy_acc: got %b want 0", cmd_ready); end
            end
            if (e == 319) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bnd_rdy_hold: got %b want 0", cmd_ready); end
            end
            if (e == 320) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bnd_rdy_rise: got %b want 1", cmd_ready); end
            end
        end
        cmd_ch = 1'b0;
    endtask

    task automatic test_reset_dead();
        logic exp_ft;
        wait_cyc(340);
        cmd_ch = 1'b0; cmd_data = 16'h0003; cmd_valid = 1'b1;
        wait_cyc(341);
        cmd_valid = 1'b0;
        wait_cyc(370);
        checks++; if (spd !== 2'b10) begin errors++; $display("FAIL dead_spd: got %b want 10", spd); end
        checks++; if (dir[0] !== 1'b1) begin errors++; $display("FAIL dead_dir0: got %b want 1", dir[0]); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL dead_rdy: got %b want 0", cmd_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (spd !== 2'b00 || dir !== 2'b00 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL async_rst: spd=%b dir=%b ft=%b want 00/00/0", spd, dir, frame_tick);
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL async_rdy0: got %b want 1", cmd_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 60; e++) begin
            wait_cyc(e);
            exp_ft = (e > 0) && (e % 20 == 0);
            checks++; if (spd !== 2'b00 || dir !== 2'b00) begin errors++; $display("FAIL post_out@%0d: spd=%b dir=%b want 00/00", e, spd, dir); end
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rdy@%0d: got %b want 1", e, cmd_ready); end
            checks++; if (frame_tick !== exp_ft) begin errors++; $display("FAIL post_ft@%0d: got %b want %b", e, frame_tick, exp_ft); end
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_saturate();
        test_reversal();
        test_back_to_back();
        test_reset_dead();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Parametrised multi-channel PWM generator, successor to the single-channel PWM core. It runs from one system clock and uses an internal clock-enable prescaler instead of derived clocks. Per-channel speed/direction commands arrive over a valid/ready port from the sequencer or program-counter/memory path. Updates are applied only at PWM period boundaries, so outputs are glitch-free. A reversal of direction inserts a programmable dead time.

## Interface
Parameters:
- NUM_CH, 2: number of PWM channels (≥1).
- PRESCALE, 25: clk cycles per PWM tick (≥1); 5 MHz / 25 = 200 kHz tick.
- PERIOD, 1000: ticks per PWM period (2..32768).
- DEAD_PERIODS, 2: full periods with spd forced low on a direction reversal (0 disables dead time).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  the channel addressed by cmd_ch can accept a command.
- cmd_ch  in  max(1,$clog2(NUM_CH))  target channel; out-of-range index gives cmd_ready=0.
- cmd_data  in  16  [15]=dir, [14:0]=duty in ticks.
- spd  out  NUM_CH  PWM outputs.
- dir  out  NUM_CH  direction outputs.
- frame_tick  out  1  one-clk pulse at each period start.

## Operation
- Prescaler pre_cnt counts 0..PRESCALE-1 on every clk and wraps. tick=1 in the cycle where pre_cnt==PRESCALE-1.
- period_cnt ($clog2(PERIOD) bits) advances on tick and wraps PERIOD-1→0. boundary = tick && period_cnt==PERIOD-1.
- Per channel:
  - pending flag and pend_data register.
  - duty_act (15 bits) and dir_act.
  - FSM {RUN, DEAD}.
  - dead_cnt.
- cmd_ready = !pending[cmd_ch] (combinational). A command is accepted when cmd_valid && cmd_ready: pending[ch]←1, pend_data[ch]←cmd_data.
- The boundary decision uses the pending state from before the current cycle. A command accepted in a boundary cycle is applied at the next boundary.
- RUN state, at boundary with pending=1:
  - If new dir ≠ dir_act, duty_act ≠ 0 and DEAD_PERIODS>0: duty_act←0, dead_cnt←DEAD_PERIODS-1, go to DEAD. pending stays 1 and dir_act is unchanged.
  - Otherwise: duty_act←pend_data[14:0], dir_act←pend_data[15], pending←0.
- DEAD state, at boundary:
  - If dead_cnt==0: load duty_act and dir_act from pend_data, pending←0, go to RUN.
  - Otherwise dead_cnt←dead_cnt-1.
  - cmd_ready for the channel stays 0 for the whole dead time, so a reversal cannot be overridden.
- Compare: spd[ch] ← (zero-extended period_cnt < duty_act), registered.
  - duty 0 gives constant low.
  - duty ≥ PERIOD gives constant high (saturates; no wrap).
- dir[ch] ← dir_act (registered).
- frame_tick is registered and is high for exactly one clk, in the cycle after a boundary.
- Channels are independent. Any number of channels may update on the same boundary.
- Reset, asserted at any time including mid-dead-time:
  - pre_cnt, period_cnt, duty_act, dir_act, pending, pend_data and dead_cnt are cleared; FSM goes to RUN.
  - spd=0, dir=0, frame_tick=0, cmd_ready=1 (for in-range cmd_ch).
  - Nothing resumes after reset.

## Timing
- Prescaler and period counter are free-running from the first clk edge after rst deasserts.
- First boundary occurs PERIOD·PRESCALE clks after reset release; boundaries then repeat every PERIOD·PRESCALE clks.
- spd lags period_cnt by 1 clk. A duty change is visible on spd 1 clk after period_cnt becomes 0 following the applying boundary.
- Accept→output latency, no dead time: between 1 clk and PERIOD·PRESCALE+1 clks, depending on the phase within the period.
- Reversal: spd is low for exactly DEAD_PERIODS full periods. dir toggles in the same cycle that the new duty first drives spd.
- cmd_ready falls in the cycle after accept and rises in the cycle after the applying boundary.

## Test plan
Bench parameters: NUM_CH=2, PRESCALE=2, PERIOD=10, DEAD_PERIODS=2.

1. Reset, then idle → spd=00, dir=00, cmd_ready=1. frame_tick pulses every 20 clks, first pulse 21 clks after release.
2. Send ch0 cmd 0x0003 → after next boundary, spd[0] is high 6 clks and low 14 clks per period. spd[1]=0. cmd_ready for ch0 returns to 1.
3. Send ch1 cmd 0x7FFF → spd[1] is constant high. Then send 0x0000 → spd[1] is constant low from the next period.
4. With ch0 running duty 3, dir 0, send 0x8005 → spd[0] low for 40 clks, dir[0]=0 and ch0 cmd_ready=0 throughout. Then dir[0]=1 and spd[0] is high 10 of 20 clks.
5. Backpressure: second ch0 cmd while ch0 is pending → cmd_ready=0, not accepted; a ch1 cmd in the same cycle is accepted. A cmd accepted in a boundary cycle applies one period later.
6. Assert rst in the middle of ch0's dead time → spd, dir and frame_tick go 0 immediately (asynchronous). After release, cmd_ready=1 and the old pend_data is never applied.
